// File: rtl/des_sbox_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : des_sbox_sched_if
//  Purpose  : Bundles the din stream, the shared S-box lookup port and the
//             dout stream of the DES S-box scheduler.
//             master = the scheduler core, slave = its surroundings.
//  Revision : 1.0  initial release
// ============================================================================
interface des_sbox_sched_if;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] din;
  logic        sb_req;
  logic [2:0]  sb_sel;
  logic [5:0]  sb_addr;
  logic [3:0]  sb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        busy;

  modport master (
    input  in_valid, din, sb_data, out_ready,
    output in_ready, sb_req, sb_sel, sb_addr, out_valid, dout, busy
  );

  modport slave (
    output in_valid, din, sb_data, out_ready,
    input  in_ready, sb_req, sb_sel, sb_addr, out_valid, dout, busy
  );
endinterface
`default_nettype wire

// File: rtl/des_sbox_sched.sv
`default_nettype none
// ============================================================================
//  Module   : des_sbox_sched
//  Purpose  : Shares one S-box lookup port across the eight S-box lookups of
//             a DES round: issues one 6-bit lookup per cycle, gathers the
//             4-bit answers into the 32-bit pre-permutation word and hands it
//             out over valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
module des_sbox_sched #(
  parameter int LOOKUP_LAT = 1  // sb_req cycle to sb_data valid, 0..3
) (
  input  logic                   clk,
  input  logic                   rst,  // asynchronous, active-low
  des_sbox_sched_if.master       bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [2:0] LAST_SEL = 3'd7;

  logic [1:0]  state_q,     state_d;
  logic [47:0] shadow_q,    shadow_d;
  logic        sb_req_q,    sb_req_d;
  logic [2:0]  sb_sel_q,    sb_sel_d;     // also serves as the issue counter
  logic [5:0]  sb_addr_q,   sb_addr_d;
  logic [2:0]  cap_cnt_q,   cap_cnt_d;
  logic [31:0] res_q,       res_d;
  logic        in_ready_q,  in_ready_d;
  logic        out_valid_q, out_valid_d;

  logic        accept;
  logic        tag_vld;  // a lookup answer is on sb_data this cycle
  logic [2:0]  tag_sel;  // which box that answer belongs to

  // Box idx input chunk: box 0 (S1) takes the most significant six bits.
  function automatic logic [5:0] chunk(input logic [47:0] w, input logic [2:0] idx);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      if (idx == 3'(i)) c = w[47-6*i -: 6];
    end
    return c;
  endfunction

  assign accept = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;

  generate
    if (LOOKUP_LAT == 0) begin : g_tag_comb
      // Combinational lookup: the answer belongs to the request on the port now.
      assign tag_vld = sb_req_q;
      assign tag_sel = sb_sel_q;
    end else begin : g_tag_pipe
      logic [LOOKUP_LAT-1:0] vld_q, vld_d;
      logic [2:0]            sel_q [LOOKUP_LAT];
      logic [2:0]            sel_d [LOOKUP_LAT];

      // Shift the issued {valid, sel} tag along in step with the lookup latency.
      always_comb begin
        vld_d[0] = sb_req_q;
        sel_d[0] = sb_sel_q;
        for (int i = 1; i < LOOKUP_LAT; i++) begin
          vld_d[i] = vld_q[i-1];
          sel_d[i] = sel_q[i-1];
        end
      end

      // Tag pipeline registers; reset drops every in-flight lookup.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q <= '0;
          for (int i = 0; i < LOOKUP_LAT; i++) sel_q[i] <= 3'd0;
        end else begin
          vld_q <= vld_d;
          for (int i = 0; i < LOOKUP_LAT; i++) sel_q[i] <= sel_d[i];
        end
      end

      assign tag_vld = vld_q[LOOKUP_LAT-1];
      assign tag_sel = sel_q[LOOKUP_LAT-1];
    end
  endgenerate

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      sb_req_q    <= 1'b0;
      sb_sel_q    <= 3'd0;
      sb_addr_q   <= 6'd0;
      cap_cnt_q   <= 3'd0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      sb_req_q    <= sb_req_d;
      sb_sel_q    <= sb_sel_d;
      sb_addr_q   <= sb_addr_d;
      cap_cnt_q   <= cap_cnt_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: issue eight lookups, wait for the last answer, then hand off.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (sb_sel_q == LAST_SEL) state_d = (LOOKUP_LAT == 0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (tag_vld && (cap_cnt_q == LAST_SEL)) state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath: lookup issue, nibble capture, handshake flags.
  always_comb begin
    shadow_d  = shadow_q;
    sb_req_d  = 1'b0;
    sb_sel_d  = sb_sel_q;
    sb_addr_d = sb_addr_q;
    cap_cnt_d = cap_cnt_q;
    res_d     = res_q;

    if (accept) begin
      shadow_d  = bus.din;
      sb_req_d  = 1'b1;
      sb_sel_d  = 3'd0;
      sb_addr_d = chunk(bus.din, 3'd0);
      cap_cnt_d = 3'd0;
    end else if ((state_q == ST_ISSUE) && (sb_sel_q != LAST_SEL)) begin
      // Stopping at sel 7 keeps the counter from wrapping into a 9th request.
      sb_req_d  = 1'b1;
      sb_sel_d  = sb_sel_q + 3'd1;
      sb_addr_d = chunk(shadow_q, sb_sel_q + 3'd1);
    end

    if (tag_vld) begin
      cap_cnt_d = cap_cnt_q + 3'd1;
      for (int i = 0; i < 8; i++) begin
        if (tag_sel == 3'(i)) res_d[31-4*i -: 4] = bus.sb_data;
      end
    end

    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.sb_req    = sb_req_q;
  assign bus.sb_sel    = sb_sel_q;
  assign bus.sb_addr   = sb_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = res_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_des_sbox_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_sbox_sched
//  Purpose  : Self-checking bench for des_sbox_sched at lookup latencies
//             0, 1 and 3, using a DES S1..S8 ROM model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_des_sbox_sched;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [47:0] din;
  logic        out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  des_sbox_sched_if if_l0 ();
  des_sbox_sched_if if_l1 ();
  des_sbox_sched_if if_l3 ();

  des_sbox_sched #(.LOOKUP_LAT(0)) u_l0 (.clk(clk), .rst(rst), .bus(if_l0));
  des_sbox_sched #(.LOOKUP_LAT(1)) u_l1 (.clk(clk), .rst(rst), .bus(if_l1));
  des_sbox_sched #(.LOOKUP_LAT(3)) u_l3 (.clk(clk), .rst(rst), .bus(if_l3));

  assign if_l0.in_valid  = in_valid;
  assign if_l1.in_valid  = in_valid;
  assign if_l3.in_valid  = in_valid;
  assign if_l0.din       = din;
  assign if_l1.din       = din;
  assign if_l3.din       = din;
  assign if_l0.out_ready = out_ready;
  assign if_l1.out_ready = out_ready;
  assign if_l3.out_ready = out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DES S-boxes S1..S8, each 4 rows of 16, row-major.
  localparam bit [3:0] SBOX [0:511] = '{
    14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
    4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13,
    15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
    0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9,
    10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
    13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12,
    7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
    10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14,
    2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
    4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3,
    12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
    9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13,
    4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
    1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12,
    13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
    7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11
  };

  // Standard DES lookup: row from the outer bits, column from the inner four.
  function automatic logic [3:0] sbox_f(input logic [2:0] box, input logic [5:0] a);
    int idx;
    idx = 64 * int'(box) + 16 * int'({a[5], a[0]}) + int'(a[4:1]);
    return SBOX[idx];
  endfunction

  function automatic logic [5:0] chunk_of(input logic [47:0] w, input int i);
    logic [47:0] t;
    t = w >> (6 * (7 - i));
    return t[5:0];
  endfunction

  function automatic logic [31:0] ref_dout(input logic [47:0] w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[27:0], sbox_f(3'(i), chunk_of(w, i))};
    return r;
  endfunction

  function automatic logic [47:0] rand48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  // S-box resources, one per latency.
  assign if_l0.sb_data = if_l0.sb_req ? sbox_f(if_l0.sb_sel, if_l0.sb_addr) : 4'h9;

  logic       v1;
  logic [2:0] s1;
  logic [5:0] a1;
  always @(posedge clk) begin
    v1 <= if_l1.sb_req;
    s1 <= if_l1.sb_sel;
    a1 <= if_l1.sb_addr;
  end
  assign if_l1.sb_data = v1 ? sbox_f(s1, a1) : 4'h6;

  logic       v3 [3];
  logic [2:0] s3 [3];
  logic [5:0] a3 [3];
  always @(posedge clk) begin
    v3[0] <= if_l3.sb_req;  s3[0] <= if_l3.sb_sel;  a3[0] <= if_l3.sb_addr;
    v3[1] <= v3[0];         s3[1] <= s3[0];         a3[1] <= a3[0];
    v3[2] <= v3[1];         s3[2] <= s3[1];         a3[2] <= a3[1];
  end
  assign if_l3.sb_data = v3[2] ? sbox_f(s3[2], a3[2]) : 4'h3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!(if_l0.in_ready && if_l1.in_ready && if_l3.in_ready) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ready_timeout", 64'(t < 50), 64'd1);
  endtask

  // One word through all three instances; out_ready held low until all are in DONE.
  task automatic do_word(input logic [47:0] v);
    logic [31:0] exp_w;
    int          ov_at [3];
    int          pulses [3];
    logic [31:0] dq [3];
    exp_w = ref_dout(v);
    for (int d = 0; d < 3; d++) begin ov_at[d] = 0; pulses[d] = 0; dq[d] = '0; end
    wait_ready();
    in_valid = 1'b1;
    din      = v;
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      if (n == 1) begin in_valid = 1'b0; din = rand48(); end
      if (if_l0.sb_req) pulses[0]++;
      if (if_l1.sb_req) pulses[1]++;
      if (if_l3.sb_req) pulses[2]++;
      if (if_l0.out_valid && ov_at[0] == 0) begin ov_at[0] = n; dq[0] = if_l0.dout; end
      if (if_l1.out_valid && ov_at[1] == 0) begin ov_at[1] = n; dq[1] = if_l1.dout; end
      if (if_l3.out_valid && ov_at[2] == 0) begin ov_at[2] = n; dq[2] = if_l3.dout; end
      if (n <= 8) begin
        chk("issue_req",  64'(if_l1.sb_req),  64'd1);
        chk("issue_sel",  64'(if_l1.sb_sel),  64'(n - 1));
        chk("issue_addr", 64'(if_l1.sb_addr), 64'(chunk_of(v, n - 1)));
        chk("issue_busy", 64'(if_l1.busy),    64'd1);
      end else if (n == 9) begin
        chk("issue_stop", 64'(if_l1.sb_req), 64'd0);
      end
      if (n >= 13) begin
        chk("hold_valid",    64'(if_l1.out_valid), 64'd1);
        chk("hold_dout",     64'(if_l1.dout),      64'(exp_w));
        chk("hold_in_ready", 64'(if_l1.in_ready),  64'd0);
        in_valid = ((n % 2) == 1);
        din      = rand48();
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("post_valid_l1",    64'(if_l1.out_valid), 64'd0);
    chk("post_in_ready_l1", 64'(if_l1.in_ready),  64'd1);
    chk("post_dout_hold",   64'(if_l1.dout),      64'(exp_w));
    chk("post_valid_l0",    64'(if_l0.out_valid), 64'd0);
    chk("post_valid_l3",    64'(if_l3.out_valid), 64'd0);
    chk("ov_cycle_l0", 64'(ov_at[0]), 64'd9);
    chk("ov_cycle_l1", 64'(ov_at[1]), 64'd10);
    chk("ov_cycle_l3", 64'(ov_at[2]), 64'd12);
    chk("dout_l0", 64'(dq[0]), 64'(exp_w));
    chk("dout_l1", 64'(dq[1]), 64'(exp_w));
    chk("dout_l3", 64'(dq[2]), 64'(exp_w));
    chk("pulses_l0", 64'(pulses[0]), 64'd8);
    chk("pulses_l1", 64'(pulses[1]), 64'd8);
    chk("pulses_l3", 64'(pulses[2]), 64'd8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [47:0] w1, w2;
    int          second, pulses, nov;
    int          ov_n [2];
    logic [31:0] ov_d [2];

    rst = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(if_l1.in_ready),  64'd0);
    chk("rst_sb_req",    64'(if_l1.sb_req),    64'd0);
    chk("rst_sb_sel",    64'(if_l1.sb_sel),    64'd0);
    chk("rst_sb_addr",   64'(if_l1.sb_addr),   64'd0);
    chk("rst_out_valid", 64'(if_l1.out_valid), 64'd0);
    chk("rst_dout",      64'(if_l1.dout),      64'd0);
    chk("rst_busy",      64'(if_l1.busy),      64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(if_l1.in_ready), 64'd1);

    // Directed vectors, then random words.
    do_word(48'h0);
    chk("ref_zero", 64'(ref_dout(48'h0)), 64'h0000_0000_EFA7_2C4D);
    do_word(48'hFFFF_FFFF_FFFF);
    for (int k = 0; k < 4; k++) do_word(rand48());

    // Abort during the 4th issue cycle.
    wait_ready();
    in_valid = 1'b1;
    din      = rand48();
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_sel", 64'(if_l1.sb_sel), 64'd3);
    rst = 1'b0;
    #1;
    chk("abort_sb_req",    64'(if_l1.sb_req),    64'd0);
    chk("abort_busy",      64'(if_l1.busy),      64'd0);
    chk("abort_out_valid", 64'(if_l1.out_valid), 64'd0);
    chk("abort_in_ready",  64'(if_l1.in_ready),  64'd0);
    chk("abort_dout",      64'(if_l1.dout),      64'd0);
    chk("abort_busy_l3",   64'(if_l3.busy),      64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_idle_ready", 64'(if_l1.in_ready), 64'd1);
    do_word(48'hFFFF_FFFF_FFFF);

    // Back-to-back with out_ready tied high: one word per 10+LOOKUP_LAT cycles.
    out_ready = 1'b1;
    wait_ready();
    w1 = rand48();
    w2 = rand48();
    in_valid = 1'b1;
    din      = w1;
    second = 0; pulses = 0; nov = 0;
    ov_n[0] = 0; ov_n[1] = 0; ov_d[0] = '0; ov_d[1] = '0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) din = w2;
      if (if_l1.sb_req) pulses++;
      if (if_l1.out_valid) begin
        if (nov < 2) begin ov_n[nov] = n; ov_d[nov] = if_l1.dout; end
        nov++;
      end
      if (second == 0 && if_l1.in_ready) second = n;
      if (second != 0 && n == second + 1) in_valid = 1'b0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_second_accept", 64'(second),  64'd11);
    chk("b2b_pulses",        64'(pulses),  64'd16);
    chk("b2b_words_out",     64'(nov),     64'd2);
    chk("b2b_ov1_cycle",     64'(ov_n[0]), 64'd10);
    chk("b2b_ov2_cycle",     64'(ov_n[1]), 64'd21);
    chk("b2b_dout1",         64'(ov_d[0]), 64'(ref_dout(w1)));
    chk("b2b_dout2",         64'(ov_d[1]), 64'(ref_dout(w2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
